// File: rtl/prbs7_xnor_checker.sv
// Self-synchronising checker for the XNOR-feedback PRBS7 stream (x^7 + x^6 + 1).
// Define PRBS7_CHK_BITCNT_EN to add the BIT_CNT locked-beat counter output.
module prbs7_xnor_checker #(
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int ERR_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DIN_VLD,
  input  logic             DIN,
  input  logic             CLR_ERR,
  output logic             LOCKED,
  output logic             ERR,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic             ERR_SAT
`ifdef PRBS7_CHK_BITCNT_EN
  ,
  output logic [31:0]      BIT_CNT
`endif
);

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [7:0]       LOCK_MATCH   = 8'(LOCK_CNT);
  localparam logic [7:0]       UNLOCK_MATCH = 8'(UNLOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX      = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ZERO     = {ERR_W{1'b0}};
  localparam logic [ERR_W-1:0] ERR_ONE      = ERR_W'(1'b1);

  function automatic logic prbs7_pred(input logic [6:0] sr);
    return ~(sr[6] ^ sr[5]);
  endfunction

  state_t           state_r, state_nxt_s;
  logic [6:0]       sr_r, sr_nxt_s;
  logic [2:0]       fill_r, fill_nxt_s;
  logic [7:0]       mcnt_r, mcnt_nxt_s;
  logic [7:0]       ucnt_r, ucnt_nxt_s;
  logic             pred_s;
  logic             err_beat_s;
  logic             locked_r;
  logic             err_r;
  logic [ERR_W-1:0] err_cnt_r, err_cnt_nxt_s;
  logic             err_sat_r;
`ifdef PRBS7_CHK_BITCNT_EN
  logic [31:0]      bit_cnt_r, bit_cnt_nxt_s;
`endif

  // Search/lock state machine next-state and prediction tracking.
  always_comb begin
    pred_s      = prbs7_pred(sr_r);
    state_nxt_s = state_r;
    sr_nxt_s    = sr_r;
    fill_nxt_s  = fill_r;
    mcnt_nxt_s  = mcnt_r;
    ucnt_nxt_s  = ucnt_r;
    err_beat_s  = 1'b0;
    if (DIN_VLD) begin
      case (state_r)
        ST_SEARCH: begin
          sr_nxt_s = {sr_r[5:0], DIN};
          if (fill_r != 3'd7) begin
            fill_nxt_s = fill_r + 3'd1;
          end else if ((DIN == pred_s) && (sr_r != 7'h7F)) begin
            if ((mcnt_r + 8'd1) == LOCK_MATCH) begin
              state_nxt_s = ST_LOCKED;
              mcnt_nxt_s  = 8'd0;
              ucnt_nxt_s  = 8'd0;
            end else begin
              mcnt_nxt_s = mcnt_r + 8'd1;
            end
          end else begin
            mcnt_nxt_s = 8'd0;
          end
        end
        ST_LOCKED: begin
          // Feed back our own prediction so a bad bit cannot corrupt later ones.
          sr_nxt_s = {sr_r[5:0], pred_s};
          if (DIN != pred_s) begin
            err_beat_s = 1'b1;
            if ((ucnt_r + 8'd1) == UNLOCK_MATCH) begin
              state_nxt_s = ST_SEARCH;
              fill_nxt_s  = 3'd0;
              mcnt_nxt_s  = 8'd0;
              ucnt_nxt_s  = 8'd0;
            end else begin
              ucnt_nxt_s = ucnt_r + 8'd1;
            end
          end else begin
            ucnt_nxt_s = 8'd0;
          end
        end
        default: begin
          state_nxt_s = ST_SEARCH;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Saturating error counter; a clear coinciding with an error leaves one count.
  always_comb begin
    err_cnt_nxt_s = err_cnt_r;
    if (CLR_ERR) begin
      err_cnt_nxt_s = err_beat_s ? ERR_ONE : ERR_ZERO;
    end else if (err_beat_s && (err_cnt_r != ERR_MAX)) begin
      err_cnt_nxt_s = err_cnt_r + ERR_ONE;
    end else begin
      err_cnt_nxt_s = err_cnt_r;
    end
  end

`ifdef PRBS7_CHK_BITCNT_EN
  // Locked-beat counter, wrapping at 2^32.
  always_comb begin
    bit_cnt_nxt_s = bit_cnt_r;
    if (CLR_ERR) begin
      bit_cnt_nxt_s = 32'd0;
    end else if (DIN_VLD && (state_r == ST_LOCKED)) begin
      bit_cnt_nxt_s = bit_cnt_r + 32'd1;
    end else begin
      bit_cnt_nxt_s = bit_cnt_r;
    end
  end
`endif

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_SEARCH;
      sr_r      <= 7'h00;
      fill_r    <= 3'd0;
      mcnt_r    <= 8'd0;
      ucnt_r    <= 8'd0;
      locked_r  <= 1'b0;
      err_r     <= 1'b0;
      err_cnt_r <= ERR_ZERO;
      err_sat_r <= 1'b0;
`ifdef PRBS7_CHK_BITCNT_EN
      bit_cnt_r <= 32'd0;
`endif
    end else begin
      state_r   <= state_nxt_s;
      sr_r      <= sr_nxt_s;
      fill_r    <= fill_nxt_s;
      mcnt_r    <= mcnt_nxt_s;
      ucnt_r    <= ucnt_nxt_s;
      locked_r  <= (state_nxt_s == ST_LOCKED);
      err_r     <= err_beat_s;
      err_cnt_r <= err_cnt_nxt_s;
      err_sat_r <= (err_cnt_nxt_s == ERR_MAX);
`ifdef PRBS7_CHK_BITCNT_EN
      bit_cnt_r <= bit_cnt_nxt_s;
`endif
    end
  end

  assign LOCKED  = locked_r;
  assign ERR     = err_r;
  assign ERR_CNT = err_cnt_r;
  assign ERR_SAT = err_sat_r;
`ifdef PRBS7_CHK_BITCNT_EN
  assign BIT_CNT = bit_cnt_r;
`endif

endmodule

// File: tb/tb_prbs7_xnor_checker.sv
// Directed bench for prbs7_xnor_checker: default instance plus an ERR_W=2 instance
// sharing the same stimulus.
module tb_prbs7_xnor_checker;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        DIN_VLD = 1'b0;
  logic        DIN = 1'b0;
  logic        CLR_ERR = 1'b0;
  logic        locked_a, err_a, err_sat_a;
  logic [15:0] err_cnt_a;
  logic        locked_b, err_b, err_sat_b;
  logic [1:0]  err_cnt_b;
`ifdef PRBS7_CHK_BITCNT_EN
  logic [31:0] bit_cnt_a, bit_cnt_b;
`endif

  logic [6:0] gen_sr;
  int passed = 0;
  int total  = 0;

  always #5 CLK = ~CLK;

  prbs7_xnor_checker dut_a (
    .CLK(CLK), .RST(RST), .DIN_VLD(DIN_VLD), .DIN(DIN), .CLR_ERR(CLR_ERR),
    .LOCKED(locked_a), .ERR(err_a), .ERR_CNT(err_cnt_a), .ERR_SAT(err_sat_a)
`ifdef PRBS7_CHK_BITCNT_EN
    , .BIT_CNT(bit_cnt_a)
`endif
  );

  prbs7_xnor_checker #(.ERR_W(2)) dut_b (
    .CLK(CLK), .RST(RST), .DIN_VLD(DIN_VLD), .DIN(DIN), .CLR_ERR(CLR_ERR),
    .LOCKED(locked_b), .ERR(err_b), .ERR_CNT(err_cnt_b), .ERR_SAT(err_sat_b)
`ifdef PRBS7_CHK_BITCNT_EN
    , .BIT_CNT(bit_cnt_b)
`endif
  );

  task automatic next_gen(output logic b);
    b = ~(gen_sr[6] ^ gen_sr[5]);
    gen_sr = {gen_sr[5:0], b};
  endtask

  task automatic drive(input logic v, input logic d);
    DIN_VLD = v;
    DIN = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    CLR_ERR = 1'b0;
    drive(1'b0, 1'b0);
    RST = 1'b0;
    gen_sr = 7'h00;
  endtask

  task automatic clean_beats(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      next_gen(b);
      drive(1'b1, b);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    drive(1'b1, 1'b1);
    RST = 1'b0;
    total++; if (locked_a !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked_a); else passed++;
    total++; if (err_a !== 1'b0) $display("FAIL reset_err: got %b want 0", err_a); else passed++;
    total++; if (err_cnt_a !== 16'd0) $display("FAIL reset_err_cnt: got %0d want 0", err_cnt_a); else passed++;
    total++; if (err_sat_a !== 1'b0) $display("FAIL reset_err_sat: got %b want 0", err_sat_a); else passed++;
    total++; if (err_sat_b !== 1'b0) $display("FAIL reset_err_sat_w2: got %b want 0", err_sat_b); else passed++;
    gen_sr = 7'h00;
  endtask

  task automatic test_clean_stream();
    logic b;
    int err_seen = 0;
    int lock_drop = 0;
    do_reset();
    for (int n = 1; n <= 500; n++) begin
      next_gen(b);
      drive(1'b1, b);
      if (n == 22) begin
        total++; if (locked_a !== 1'b0) $display("FAIL clean_unlocked_22: got %b want 0", locked_a); else passed++;
      end
      if (n == 23) begin
        total++; if (locked_a !== 1'b1) $display("FAIL clean_locked_23: got %b want 1", locked_a); else passed++;
      end
      if (err_a !== 1'b0 || err_b !== 1'b0) err_seen++;
      if (n > 23 && locked_a !== 1'b1) lock_drop++;
    end
    total++; if (err_seen != 0) $display("FAIL clean_err_pulses: got %0d want 0", err_seen); else passed++;
    total++; if (lock_drop != 0) $display("FAIL clean_lock_hold: got %0d drops want 0", lock_drop); else passed++;
    total++; if (err_cnt_a !== 16'd0) $display("FAIL clean_err_cnt: got %0d want 0", err_cnt_a); else passed++;
  endtask

  task automatic test_single_error();
    logic b;
    int pulses = 0;
    next_gen(b);
    drive(1'b1, ~b);
    total++; if (err_a !== 1'b1) $display("FAIL single_err_pulse: got %b want 1", err_a); else passed++;
    total++; if (err_cnt_a !== 16'd1) $display("FAIL single_err_cnt: got %0d want 1", err_cnt_a); else passed++;
    total++; if (locked_a !== 1'b1) $display("FAIL single_locked: got %b want 1", locked_a); else passed++;
    for (int i = 0; i < 20; i++) begin
      next_gen(b);
      drive(1'b1, b);
      if (err_a !== 1'b0) pulses++;
    end
    total++; if (pulses != 0) $display("FAIL single_extra_err: got %0d want 0", pulses); else passed++;
    total++; if (err_cnt_a !== 16'd1) $display("FAIL single_err_cnt_after: got %0d want 1", err_cnt_a); else passed++;
    total++; if (locked_a !== 1'b1) $display("FAIL single_locked_after: got %b want 1", locked_a); else passed++;
  endtask

  task automatic test_loss_of_lock();
    logic b;
    do_reset();
    clean_beats(30);
`ifdef PRBS7_CHK_BITCNT_EN
    total++; if (bit_cnt_a !== 32'd7) $display("FAIL lol_bit_cnt: got %0d want 7", bit_cnt_a); else passed++;
`endif
    for (int i = 1; i <= 4; i++) begin
      next_gen(b);
      drive(1'b1, ~b);
      total++; if (err_a !== 1'b1) $display("FAIL lol_err_%0d: got %b want 1", i, err_a); else passed++;
      if (i == 3) begin
        total++; if (locked_a !== 1'b1) $display("FAIL lol_locked_3: got %b want 1", locked_a); else passed++;
      end
    end
    total++; if (locked_a !== 1'b0) $display("FAIL lol_unlocked_4: got %b want 0", locked_a); else passed++;
    total++; if (err_cnt_a !== 16'd4) $display("FAIL lol_err_cnt: got %0d want 4", err_cnt_a); else passed++;
    for (int n = 1; n <= 23; n++) begin
      next_gen(b);
      drive(1'b1, b);
      if (n == 22) begin
        total++; if (locked_a !== 1'b0) $display("FAIL relock_22: got %b want 0", locked_a); else passed++;
      end
    end
    total++; if (locked_a !== 1'b1) $display("FAIL relock_23: got %b want 1", locked_a); else passed++;
  endtask

  task automatic test_lockup();
    logic b;
    int locked_seen = 0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b1);
      if (locked_a !== 1'b0) locked_seen++;
    end
    total++; if (locked_seen != 0) $display("FAIL lockup_locked: got %0d want 0", locked_seen); else passed++;
    gen_sr = 7'h00;
    for (int n = 1; n <= 23; n++) begin
      next_gen(b);
      drive(1'b1, b);
      if (n == 22) begin
        total++; if (locked_a !== 1'b0) $display("FAIL lockup_recover_22: got %b want 0", locked_a); else passed++;
      end
    end
    total++; if (locked_a !== 1'b1) $display("FAIL lockup_recover_23: got %b want 1", locked_a); else passed++;
  endtask

  task automatic test_saturation();
    logic b;
    do_reset();
    clean_beats(30);
    for (int e = 0; e < 5; e++) begin
      next_gen(b);
      drive(1'b1, ~b);
      clean_beats(3);
    end
    total++; if (err_cnt_b !== 2'd3) $display("FAIL sat_err_cnt_w2: got %0d want 3", err_cnt_b); else passed++;
    total++; if (err_sat_b !== 1'b1) $display("FAIL sat_flag_w2: got %b want 1", err_sat_b); else passed++;
    total++; if (err_cnt_a !== 16'd5) $display("FAIL sat_err_cnt_w16: got %0d want 5", err_cnt_a); else passed++;
    total++; if (err_sat_a !== 1'b0) $display("FAIL sat_flag_w16: got %b want 0", err_sat_a); else passed++;
    CLR_ERR = 1'b1;
    next_gen(b);
    drive(1'b1, ~b);
    CLR_ERR = 1'b0;
    total++; if (err_cnt_b !== 2'd1) $display("FAIL clr_err_cnt_w2: got %0d want 1", err_cnt_b); else passed++;
    total++; if (err_sat_b !== 1'b0) $display("FAIL clr_flag_w2: got %b want 0", err_sat_b); else passed++;
    total++; if (err_b !== 1'b1) $display("FAIL clr_err_pulse: got %b want 1", err_b); else passed++;
    total++; if (locked_b !== 1'b1) $display("FAIL clr_locked: got %b want 1", locked_b); else passed++;
`ifdef PRBS7_CHK_BITCNT_EN
    total++; if (bit_cnt_b !== 32'd0) $display("FAIL clr_bit_cnt: got %0d want 0", bit_cnt_b); else passed++;
`endif
  endtask

  task automatic test_gapped_and_reset();
    logic b;
    do_reset();
    for (int n = 1; n <= 23; n++) begin
      next_gen(b);
      drive(1'b1, b);
      drive(1'b0, ~b);
      drive(1'b0, b);
      if (n == 22) begin
        total++; if (locked_a !== 1'b0) $display("FAIL gap_unlocked_22: got %b want 0", locked_a); else passed++;
      end
    end
    total++; if (locked_a !== 1'b1) $display("FAIL gap_locked_23: got %b want 1", locked_a); else passed++;
    next_gen(b);
    drive(1'b1, ~b);
    drive(1'b0, b);
    total++; if (err_a !== 1'b0) $display("FAIL gap_err_idle: got %b want 0", err_a); else passed++;
    total++; if (err_cnt_a !== 16'd1) $display("FAIL gap_err_cnt: got %0d want 1", err_cnt_a); else passed++;
    next_gen(b);
    RST = 1'b1;
    drive(1'b1, ~b);
    RST = 1'b0;
    DIN_VLD = 1'b0;
    total++; if (locked_a !== 1'b0) $display("FAIL rst_locked: got %b want 0", locked_a); else passed++;
    total++; if (err_a !== 1'b0) $display("FAIL rst_err: got %b want 0", err_a); else passed++;
    total++; if (err_cnt_a !== 16'd0) $display("FAIL rst_err_cnt: got %0d want 0", err_cnt_a); else passed++;
    total++; if (err_sat_a !== 1'b0) $display("FAIL rst_err_sat: got %b want 0", err_sat_a); else passed++;
  endtask

  initial begin
    gen_sr = 7'h00;
    test_reset();
    test_clean_stream();
    test_single_error();
    test_loss_of_lock();
    test_lockup();
    test_saturation();
    test_gapped_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
